sevenseg_mux_decoder: RTL and testbench

- Receiving end of the multiplexed 7-segment display interface: segment lines A–G plus digit-select SEL.
- Samples the time-multiplexed bus, captures each digit's segment pattern once it settles, and decodes it to a hex nibble.
- Reassembles the two digits into an 8-bit value and flags illegal patterns and a stalled multiplexer.
- Used as an on-chip loopback checker and as a display-to-binary bridge for a second tile.

---
 rtl/sevenseg_mux_decoder.sv | 173 +++++++++++++++++
 tb/tb_sevenseg_mux_decoder.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/sevenseg_mux_decoder.sv
// Receiver for a two-digit multiplexed 7-segment bus: synchronises SEG/SEL, captures each
// digit once settled, decodes it to hex and reassembles {high, low} frames.
module sevenseg_mux_decoder #(
    parameter int unsigned SETTLE      = 4,
    parameter int unsigned STALE_LIMIT = 1024
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [6:0] SEG,
    input  logic       SEL,
    output logic [7:0] VALUE,
    output logic       VALID,
    output logic       ERR,
    output logic       STALE,
    output logic       CHANGED
);
    localparam int unsigned SCW = $clog2(STALE_LIMIT + 1);

    typedef enum logic [1:0] {
        WAIT_EDGE,
        SETTLING,
        HOLD
    } state_t;

    state_t         state;
    state_t         state_next;

    logic [6:0]     seg_s1;
    logic [6:0]     seg_s2;
    logic [6:0]     seg_q;
    logic           sel_s1;
    logic           sel_s2;
    logic           sel_q;

    logic           sel_edge;
    logic           sample_same;
    logic           capture;
    logic           abandon_lo;
    logic [3:0]     settle_cnt;
    logic [SCW-1:0] stale_cnt;

    logic           cap_stb;
    logic           cap_hi;
    logic [6:0]     cap_pat;
    logic [4:0]     cap_dec;
    logic           lo_ok;
    logic [3:0]     lo_nib;

    // Returns {legal, nibble}; any pattern outside the table decodes as illegal.
    function automatic logic [4:0] decode(input logic [6:0] pat);
        logic [4:0] r;
        r = '0;
        case (pat)
            7'h3F: r = 5'h10;
            7'h06: r = 5'h11;
            7'h5B: r = 5'h12;
            7'h4F: r = 5'h13;
            7'h66: r = 5'h14;
            7'h6D: r = 5'h15;
            7'h7D: r = 5'h16;
            7'h07: r = 5'h17;
            7'h7F: r = 5'h18;
            7'h6F: r = 5'h19;
            7'h77: r = 5'h1A;
            7'h7C: r = 5'h1B;
            7'h39: r = 5'h1C;
            7'h5E: r = 5'h1D;
            7'h79: r = 5'h1E;
            7'h71: r = 5'h1F;
            default: r = '0;
        endcase
        return r;
    endfunction

    always_ff @(posedge CLK) begin
        if (RST) begin
            seg_s1 <= '0;
            seg_s2 <= '0;
            seg_q  <= '0;
            sel_s1 <= 1'b0;
            sel_s2 <= 1'b0;
            sel_q  <= 1'b0;
        end else begin
            seg_s1 <= SEG;
            seg_s2 <= seg_s1;
            seg_q  <= seg_s2;
            sel_s1 <= SEL;
            sel_s2 <= sel_s1;
            sel_q  <= sel_s2;
        end
    end

    assign sel_edge    = sel_s2 ^ sel_q;
    assign sample_same = ({sel_s2, seg_s2} == {sel_q, seg_q});
    assign cap_dec     = decode(cap_pat);

    always_ff @(posedge CLK) begin
        if (RST) state <= WAIT_EDGE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            WAIT_EDGE: if (sel_edge) state_next = SETTLING;
            SETTLING:  if (capture) state_next = HOLD;
            HOLD:      if (sel_edge) state_next = SETTLING;
            default:   state_next = WAIT_EDGE;
        endcase
    end

    always_comb begin
        capture    = 1'b0;
        abandon_lo = 1'b0;
        STALE      = (stale_cnt == SCW'(STALE_LIMIT));
        if (state == SETTLING) begin
            capture    = sample_same && ((settle_cnt + 4'd1) == 4'(SETTLE));
            abandon_lo = sel_edge && !sel_q;
        end
    end

    // Any difference in SEG or SEL (a SEL edge included) restarts the settle count.
    always_ff @(posedge CLK) begin
        if (RST)                   settle_cnt <= '0;
        else if (!sample_same)     settle_cnt <= '0;
        else if (state == SETTLING) settle_cnt <= settle_cnt + 4'd1;
    end

    always_ff @(posedge CLK) begin
        if (RST)                                    stale_cnt <= '0;
        else if (sel_edge)                          stale_cnt <= '0;
        else if (stale_cnt != SCW'(STALE_LIMIT))    stale_cnt <= stale_cnt + 1'b1;
    end

    // Captured digit is decoded one cycle later, so frame outputs follow the capture by a cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cap_stb <= 1'b0;
            cap_hi  <= 1'b0;
            cap_pat <= '0;
            lo_ok   <= 1'b0;
            lo_nib  <= '0;
            VALUE   <= '0;
            VALID   <= 1'b0;
            ERR     <= 1'b0;
            CHANGED <= 1'b0;
        end else begin
            cap_stb <= capture;
            if (capture) begin
                cap_hi  <= sel_s2;
                cap_pat <= seg_s2;
            end
            VALID   <= 1'b0;
            ERR     <= 1'b0;
            CHANGED <= 1'b0;
            if (cap_stb) begin
                if (!cap_dec[4]) begin
                    ERR <= 1'b1;
                    if (!cap_hi) lo_ok <= 1'b0;
                end else if (!cap_hi) begin
                    lo_nib <= cap_dec[3:0];
                    lo_ok  <= 1'b1;
                end else if (lo_ok) begin
                    VALUE   <= {cap_dec[3:0], lo_nib};
                    VALID   <= 1'b1;
                    CHANGED <= ({cap_dec[3:0], lo_nib} != VALUE);
                    lo_ok   <= 1'b0;
                end
            end
            if (abandon_lo) lo_ok <= 1'b0;
        end
    end
endmodule

// File: tb/tb_sevenseg_mux_decoder.sv
// Directed bench for sevenseg_mux_decoder: a timestamp-based reference model checked every
// cycle, plus hand-computed literal expectations at key points of each scenario.
module tb_sevenseg_mux_decoder;
    localparam int SETTLE = 4;
    localparam int LIMIT  = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] seg = '0;
    logic       sel = 1'b0;
    logic [7:0] value;
    logic       valid;
    logic       err;
    logic       stale;
    logic       changed;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sevenseg_mux_decoder #(.SETTLE(SETTLE), .STALE_LIMIT(LIMIT)) dut (
        .CLK(clk), .RST(rst), .SEG(seg), .SEL(sel),
        .VALUE(value), .VALID(valid), .ERR(err), .STALE(stale), .CHANGED(changed)
    );

    logic [6:0] pats [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    function automatic int lookup(input logic [6:0] p);
        for (int i = 0; i < 16; i++) if (pats[i] == p) return i;
        return -1;
    endfunction

    task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: synchroniser as a shift of samples, settling judged by the
    // time since the last sample change, staleness by the time since the last SEL edge.
    int         cyc = 0;
    int         last_sel = 0;
    int         last_chg = 0;
    logic [7:0] m1 = '0, m2 = '0, m3 = '0;
    bit         phase_on = 0, captured = 0, m_lo_ok = 0, pend = 0, pend_hi = 0, ready = 0;
    logic [6:0] pend_pat = '0;
    logic [3:0] m_lo_nib = '0;
    logic [7:0] e_value = '0;
    bit         e_valid = 0, e_err = 0, e_chg = 0, e_stale = 0;
    logic [7:0] cur, prev, nv;
    int         idx;

    always @(posedge clk) begin
        cyc++;
        cur  = m2;
        prev = m3;
        if (rst) begin
            m1 = '0; m2 = '0; m3 = '0;
            phase_on = 0; captured = 0; m_lo_ok = 0; pend = 0;
            e_value = '0; e_valid = 0; e_err = 0; e_chg = 0;
            last_sel = cyc; last_chg = cyc;
        end else begin
            e_valid = 0; e_err = 0; e_chg = 0;
            if (pend) begin
                idx = lookup(pend_pat);
                if (idx < 0) begin
                    e_err = 1;
                    if (!pend_hi) m_lo_ok = 0;
                end else if (!pend_hi) begin
                    m_lo_nib = idx[3:0];
                    m_lo_ok  = 1;
                end else if (m_lo_ok) begin
                    nv      = {idx[3:0], m_lo_nib};
                    e_chg   = (nv != e_value);
                    e_value = nv;
                    e_valid = 1;
                    m_lo_ok = 0;
                end
            end
            pend = 0;
            if (cur[7] != prev[7]) begin
                if (phase_on && !captured && !prev[7]) m_lo_ok = 0;
                phase_on = 1;
                captured = 0;
                last_sel = cyc;
            end
            if (cur != prev) last_chg = cyc;
            else if (phase_on && !captured && (cyc - last_chg) == SETTLE) begin
                pend     = 1;
                pend_pat = cur[6:0];
                pend_hi  = cur[7];
                captured = 1;
            end
            m3 = m2;
            m2 = m1;
            m1 = {sel, seg};
        end
        e_stale = (cyc - last_sel) >= LIMIT;
        ready   = 1;
    end

    int n_valid = 0, n_chg = 0, n_err = 0;

    always @(negedge clk) begin
        if (ready) begin
            cmp("value", value, e_value);
            cmp("valid", {7'b0, valid}, {7'b0, e_valid});
            cmp("err", {7'b0, err}, {7'b0, e_err});
            cmp("changed", {7'b0, changed}, {7'b0, e_chg});
            cmp("stale", {7'b0, stale}, {7'b0, e_stale});
            if (valid === 1'b1) n_valid++;
            if (changed === 1'b1) n_chg++;
            if (err === 1'b1) n_err++;
        end
    end

    task automatic phase(input logic [6:0] s, input logic b, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            seg = s;
            sel = b;
        end
    endtask

    task automatic frame(input logic [7:0] v);
        phase(pats[v[3:0]], 1'b0, 20);
        phase(pats[v[7:4]], 1'b1, 20);
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        cmp("reset_value", value, 8'h00);
        cmp("reset_flags", {4'b0, valid, err, stale, changed}, 8'h00);

        // First phase has no SEL edge, first high phase has no low digit: both discarded.
        frame(8'h10);
        chk_int("t1_first_discarded", n_valid, 0);
        frame(8'h10);
        cmp("t1_value", value, 8'h10);
        cmp("t1_model_value", e_value, 8'h10);
        chk_int("t1_valid_cnt", n_valid, 1);
        chk_int("t1_chg_cnt", n_chg, 1);
        frame(8'h10);
        chk_int("t1_repeat_valid", n_valid, 2);
        chk_int("t1_repeat_nochg", n_chg, 1);

        for (int v = 0; v < 256; v++) begin
            frame(8'(v));
            if (v == 255) cmp("t2_top", value, 8'hFF);
        end
        frame(8'h00);
        cmp("t2_wrap", value, 8'h00);
        chk_int("t2_valid_cnt", n_valid, 259);
        chk_int("t2_chg_cnt", n_chg, 258);
        chk_int("t2_no_err", n_err, 0);

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            sel = 1'b0;
            seg = (i < 10 && (i % 3) == 0) ? 7'h00 : 7'h6D;
        end
        phase(7'h06, 1'b1, 20);
        cmp("t3_glitch_value", value, 8'h15);
        chk_int("t3_no_err", n_err, 0);

        phase(7'h3F, 1'b0, 20);
        phase(7'h00, 1'b1, 20);
        chk_int("t4_err_cnt", n_err, 1);
        chk_int("t4_no_valid", n_valid, 260);
        cmp("t4_value_held", value, 8'h15);

        phase(7'h06, 1'b1, 20);
        cmp("t5_stale_high", {7'b0, stale}, 8'h01);
        @(negedge clk);
        sel = 1'b0;
        seg = 7'h3F;
        repeat (2) @(negedge clk);
        cmp("t5_stale_before_sync", {7'b0, stale}, 8'h01);
        @(negedge clk);
        cmp("t5_stale_cleared", {7'b0, stale}, 8'h00);
        repeat (15) @(negedge clk);
        cmp("t5_stale_15", {7'b0, stale}, 8'h00);
        @(negedge clk);
        cmp("t5_stale_16", {7'b0, stale}, 8'h01);

        // Low digit is captured by now; a one-cycle reset must drop it.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cmp("t6_reset_value", value, 8'h00);
        phase(7'h3F, 1'b0, 5);
        phase(7'h06, 1'b1, 20);
        cmp("t6_hi_discarded", value, 8'h00);
        chk_int("t6_no_valid", n_valid, 260);
        frame(8'h13);
        cmp("t6_full_frame", value, 8'h13);
        chk_int("t6_valid", n_valid, 261);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
